stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control stage directly upstream of the four 4-bit digit counters (mm:ss stopwatch).
- Synchronizes the start/stop and clear buttons and runs the run/pause/clear state machine.
- Divides clk down to a count tick and drives each counter's Load/Count with BCD carry and wrap, using the counters' q values fed back.
- Registers the digit values for the display stage.

Parameters:
- TICK_DIV, 1000000: clk cycles per count tick; legal range 2 or more.
- MAX0, 9: terminal value, seconds-ones digit.
- MAX1, 5: terminal value, seconds-tens digit.
- MAX2, 9: terminal value, minutes-ones digit.
- MAX3, 5: terminal value, minutes-tens digit.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn_ss  in  1  start/stop button, asynchronous level.
- btn_clr  in  1  clear button, asynchronous level.
- q0, q1, q2, q3  in  4 each  current value of digit counters 0..3; digit 0 is seconds-ones.
- count  out  4  per-digit Count enable; bit i drives counter i.
- load  out  4  per-digit Load; bit i drives counter i.
- load_d  out  4  value presented on every counter's d inputs; constant 4'h0.
- running  out  1  high while state is RUN.
- tick  out  1  one-cycle prescaler pulse.
- rollover  out  1  one-cycle pulse when 59:59 wraps to 00:00.
- disp0, disp1, disp2, disp3  out  4 each  registered digit values for the display.

Behaviour:
- Reset (reset=0, async):
  - State IDLE, prescaler 0, synchronizer and edge flops 0.
  - count, load, tick, rollover, running = 0; disp0..3 = 0.
- Buttons:
  - Each button passes through a 2-flop synchronizer and a rising-edge detector.
  - An edge pulse is 1 cycle; the FSM acts on the next clk edge, 3 cycles after the level is first sampled.
  - Holding a button high produces no further edges.
- FSM states: IDLE, RUN, PAUSE, CLEAR.
  - IDLE: ss edge -> RUN; clr edge -> CLEAR.
  - RUN: ss edge -> PAUSE; clr edge ignored.
  - PAUSE: ss edge -> RUN; clr edge -> CLEAR.
  - CLEAR: lasts exactly 1 cycle, then -> IDLE. While in CLEAR: load=4'hF, count=0, prescaler forced to 0.
  - Simultaneous ss and clr edges: in IDLE/PAUSE, clr wins; in RUN, ss wins.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - tick=1 in the cycle the prescaler equals TICK_DIV-1; the prescaler then returns to 0.
  - Holds its value in PAUSE; a resumed run completes the partial period.
  - Zeroed in IDLE and CLEAR.
- Digit drive: combinational from tick and q0..q3, asserted only in the tick cycle.
  - Digit 0: if q0==MAX0 then load[0]=1 and carry1=1; else count[0]=1.
  - Digit i (i=1..3), only when carry_i=1: if qi==MAXi then load[i]=1 and carry_(i+1)=1; else count[i]=1.
  - Digits without carry get count=0 and load=0.
  - count[i] and load[i] are never both 1.
  - carry4=1 means 59:59 -> 00:00: all four load bits set, rollover=1 for that cycle. Counting continues in RUN.
- q values above MAXi are treated as terminal: load to 0 and carry.
- disp:
  - disp_i <= q_i every cycle, so it lags q by 1 cycle.
  - disp is not altered by the CLEAR state; it follows q.
- Reset asserted mid-run: outputs drop to 0 immediately. Counter contents are the counters' own responsibility.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - Adds input btn_lap (1 bit), with the same synchronizer and edge detection as the other buttons.
  - A lap edge in RUN toggles lap_hold.
  - While lap_hold=1, disp0..3 freeze at the snapshot taken in the edge cycle; counting continues.
  - lap_hold clears on entering CLEAR, on reset, or on the next lap edge.
  - Lap edges in IDLE/PAUSE are ignored.
- Undefined: no btn_lap port; disp always tracks q with a 1-cycle lag.

Test Plan (TICK_DIV=4, counters modelled):
- Reset: reset=0 -> all outputs 0, state IDLE. Release reset, no buttons -> count=0 and tick=0 for 50 cycles.
- Start: btn_ss pulse -> running=1 three cycles later. tick every 4 cycles; count=4'b0001 on each tick; q0 goes 0..9. At q0=9, tick -> load=4'b0001, count=4'b0010.
- Cascade: q={5,9,5,9} (d3..d0 = 59:59) in RUN, tick -> load=4'hF, count=0, rollover=1 for 1 cycle, next q=0000.
- Pause/resume: stop when the prescaler is at 2 -> running=0, no ticks for 20 cycles. Resume -> first tick 1 cycle after re-entering RUN (prescaler 2->3).
- Clear priority: in PAUSE, btn_ss and btn_clr rise together -> CLEAR (load=4'hF, 1 cycle) then IDLE. In RUN, btn_clr alone -> no load; state stays RUN.
- STOPWATCH_LAP_EN: lap edge at q0=3 -> disp0 holds 3 while q0 reaches 7. Second lap edge -> disp0 tracks q0 with a 1-cycle lag.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control stage for an mm:ss stopwatch built from four
// external 4-bit digit counters. Synchronizes the start/stop and clear
// buttons, runs the IDLE/RUN/PAUSE/CLEAR state machine, divides clk down to
// a count tick, drives each counter's Load/Count with BCD carry and wrap,
// and registers the counter values for the display.
// Optional feature: define STOPWATCH_LAP_EN to add a lap button that
// freezes the display while counting continues.
// state_dbg exposes the FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 CLEAR.
// Counter interface: count[i]/load[i] are combinational and only meaningful
// at the next rising clk edge; they are never both high for one digit.
module stopwatch_ctrl #(
   parameter int         TICK_DIV = 1000000,
   parameter logic [3:0] MAX0     = 4'd9,
   parameter logic [3:0] MAX1     = 4'd5,
   parameter logic [3:0] MAX2     = 4'd9,
   parameter logic [3:0] MAX3     = 4'd5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_ss,
   input  logic       btn_clr,
`ifdef STOPWATCH_LAP_EN
   input  logic       btn_lap,
`endif
   input  logic [3:0] q0,
   input  logic [3:0] q1,
   input  logic [3:0] q2,
   input  logic [3:0] q3,
   output logic [3:0] count,
   output logic [3:0] load,
   output logic [3:0] load_d,
   output logic       running,
   output logic       tick,
   output logic       rollover,
   output logic [3:0] disp0,
   output logic [3:0] disp1,
   output logic [3:0] disp2,
   output logic [3:0] disp3,
   output logic [1:0] state_dbg
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_CLEAR = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   // [0],[1] synchronize; [2] is the delayed copy used by the edge detector
   logic [2:0]    ss_sync_q, ss_sync_d, clr_sync_q, clr_sync_d;
   logic          ss_edge_q, ss_edge_d, clr_edge_q, clr_edge_d;
   logic [15:0]   disp_q, disp_d;
   logic          hold_disp;
   logic          tick_w;
   logic [3:0]    q_term, cnt_w, ld_w;
   logic [4:0]    carry;

`ifdef STOPWATCH_LAP_EN
   logic [2:0]    lap_sync_q, lap_sync_d;
   logic          lap_edge_q, lap_edge_d;
   logic          lap_hold_q, lap_hold_d;

   // lap button: synchronize, edge-detect, toggle the display hold in RUN
   always_comb begin
      lap_sync_d = {lap_sync_q[1:0], btn_lap};
      lap_edge_d = lap_sync_q[1] & ~lap_sync_q[2];
      lap_hold_d = lap_hold_q;
      if (lap_edge_q && (state_q == ST_RUN)) lap_hold_d = ~lap_hold_q;
      if (state_d == ST_CLEAR) lap_hold_d = 1'b0;
   end

   assign hold_disp = lap_hold_q;
`else
   assign hold_disp = 1'b0;
`endif

   // a tick only happens while running; a paused prescaler may sit at its last value
   assign tick_w = (state_q == ST_RUN) && (pre_q == PRE_LAST);

   // button synchronizers, edge detectors, next state, prescaler and display capture
   always_comb begin
      ss_sync_d  = {ss_sync_q[1:0], btn_ss};
      clr_sync_d = {clr_sync_q[1:0], btn_clr};
      ss_edge_d  = ss_sync_q[1] & ~ss_sync_q[2];
      clr_edge_d = clr_sync_q[1] & ~clr_sync_q[2];

      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (clr_edge_q)     state_d = ST_CLEAR;
            else if (ss_edge_q) state_d = ST_RUN;
         end
         ST_RUN: begin
            // clear is ignored while running, so start/stop always wins here
            if (ss_edge_q) state_d = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (clr_edge_q)     state_d = ST_CLEAR;
            else if (ss_edge_q) state_d = ST_RUN;
         end
         ST_CLEAR: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      unique case (state_q)
         ST_RUN:   pre_d = tick_w ? '0 : pre_q + 1'b1;
         ST_PAUSE: pre_d = pre_q;
         default:  pre_d = '0;
      endcase

      disp_d = hold_disp ? disp_q : {q3, q2, q1, q0};
   end

   // BCD carry chain: values above the terminal count are treated as terminal
   always_comb begin
      q_term   = {(q3 >= MAX3), (q2 >= MAX2), (q1 >= MAX1), (q0 >= MAX0)};
      carry    = '0;
      cnt_w    = '0;
      ld_w     = '0;
      carry[0] = tick_w;
      for (int i = 0; i < 4; i++) begin
         if (carry[i]) begin
            if (q_term[i]) begin
               ld_w[i]      = 1'b1;
               carry[i + 1] = 1'b1;
            end else begin
               cnt_w[i] = 1'b1;
            end
         end
      end
   end

   // all state registers, cleared asynchronously by the active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         pre_q      <= '0;
         ss_sync_q  <= '0;
         clr_sync_q <= '0;
         ss_edge_q  <= 1'b0;
         clr_edge_q <= 1'b0;
         disp_q     <= '0;
`ifdef STOPWATCH_LAP_EN
         lap_sync_q <= '0;
         lap_edge_q <= 1'b0;
         lap_hold_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pre_q      <= pre_d;
         ss_sync_q  <= ss_sync_d;
         clr_sync_q <= clr_sync_d;
         ss_edge_q  <= ss_edge_d;
         clr_edge_q <= clr_edge_d;
         disp_q     <= disp_d;
`ifdef STOPWATCH_LAP_EN
         lap_sync_q <= lap_sync_d;
         lap_edge_q <= lap_edge_d;
         lap_hold_q <= lap_hold_d;
`endif
      end
   end

   assign count     = (state_q == ST_CLEAR) ? 4'h0 : cnt_w;
   assign load      = (state_q == ST_CLEAR) ? 4'hF : ld_w;
   assign load_d    = 4'h0;
   assign rollover  = carry[4];
   assign tick      = tick_w;
   assign running   = (state_q == ST_RUN);
   assign disp0     = disp_q[3:0];
   assign disp1     = disp_q[7:4];
   assign disp2     = disp_q[11:8];
   assign disp3     = disp_q[15:12];
   assign state_dbg = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4. Four digit counters are modelled
// here and fed from the DUT's load/count; a small model of the control rules
// tracks expected state, prescaler phase and display contents.
module tb_stopwatch_ctrl;

   localparam int TDIV = 4;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_CLEAR = 2'd3;

   logic       clk = 1'b0;
   logic       reset, btn_ss, btn_clr;
`ifdef STOPWATCH_LAP_EN
   logic       btn_lap;
`endif
   logic [3:0] q0, q1, q2, q3;
   logic [3:0] count, load, load_d, disp0, disp1, disp2, disp3;
   logic       running, tick, rollover;
   logic [1:0] state_dbg;

   int checks = 0;
   int errors = 0;

   // counter preload request, applied at the next rising edge
   logic       pre_en;
   logic [3:0] pre0, pre1, pre2, pre3;

   // expected-behaviour model
   logic [1:0] m_state;
   int         m_pc, cyc_n, ss_at, clr_at, lap_at;
   logic       m_lap;
   logic [3:0] m_disp[4];
   logic       exp_tick, exp_roll;
   logic [3:0] exp_cnt, exp_ld;

   stopwatch_ctrl #(.TICK_DIV(TDIV)) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_ss    (btn_ss),
      .btn_clr   (btn_clr),
`ifdef STOPWATCH_LAP_EN
      .btn_lap   (btn_lap),
`endif
      .q0        (q0),
      .q1        (q1),
      .q2        (q2),
      .q3        (q3),
      .count     (count),
      .load      (load),
      .load_d    (load_d),
      .running   (running),
      .tick      (tick),
      .rollover  (rollover),
      .disp0     (disp0),
      .disp1     (disp1),
      .disp2     (disp2),
      .disp3     (disp3),
      .state_dbg (state_dbg)
   );

   // clock
   always #5 clk = ~clk;

   // digit counters: load to 0 has priority over count
   always @(posedge clk) begin
      if (pre_en) begin
         q0 <= pre0; q1 <= pre1; q2 <= pre2; q3 <= pre3;
      end else begin
         if (load[0]) q0 <= 4'd0; else if (count[0]) q0 <= q0 + 4'd1;
         if (load[1]) q1 <= 4'd0; else if (count[1]) q1 <= q1 + 4'd1;
         if (load[2]) q2 <= 4'd0; else if (count[2]) q2 <= q2 + 4'd1;
         if (load[3]) q3 <= 4'd0; else if (count[3]) q3 <= q3 + 4'd1;
      end
   end

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // expected digit drive for the current q values
   function automatic void drive_model(input logic tk, input logic [1:0] st,
                                       output logic [3:0] cnt, output logic [3:0] ld,
                                       output logic roll);
      logic [3:0] v[4];
      logic [3:0] mx[4];
      logic       c;
      v[0] = q0; v[1] = q1; v[2] = q2; v[3] = q3;
      mx[0] = 4'd9; mx[1] = 4'd5; mx[2] = 4'd9; mx[3] = 4'd5;
      cnt = 4'h0; ld = 4'h0; c = tk;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (v[i] >= mx[i]) ld[i] = 1'b1;
            else begin
               cnt[i] = 1'b1;
               c = 1'b0;
            end
         end
      end
      roll = c;
      if (st == S_CLEAR) begin
         ld  = 4'hF;
         cnt = 4'h0;
      end
   endfunction

   task automatic init_model();
      m_state = S_IDLE; m_pc = 0; m_lap = 1'b0; cyc_n = 0;
      ss_at = -1; clr_at = -1; lap_at = -1;
      for (int i = 0; i < 4; i++) m_disp[i] = 4'd0;
      exp_tick = 1'b0; exp_cnt = 4'h0; exp_ld = 4'h0; exp_roll = 1'b0;
   endtask

   // driver: advance one clock cycle, release button pulses, update the model
   task automatic cyc();
      logic [1:0] ps;
      logic       ss_e, clr_e, lap_e;
      logic [3:0] pq[4];
      ps = m_state;
      pq[0] = q0; pq[1] = q1; pq[2] = q2; pq[3] = q3;
      ss_e  = (ss_at == cyc_n);
      clr_e = (clr_at == cyc_n);
      lap_e = (lap_at == cyc_n);
      @(negedge clk);
      btn_ss = 1'b0; btn_clr = 1'b0; pre_en = 1'b0;
`ifdef STOPWATCH_LAP_EN
      btn_lap = 1'b0;
`endif
      cyc_n++;
      if (ps == S_RUN) m_pc = (m_pc == TDIV - 1) ? 0 : m_pc + 1;
      else if (ps != S_PAUSE) m_pc = 0;
      case (ps)
         S_IDLE:  if (clr_e) m_state = S_CLEAR; else if (ss_e) m_state = S_RUN;
         S_RUN:   if (ss_e) m_state = S_PAUSE;
         S_PAUSE: if (clr_e) m_state = S_CLEAR; else if (ss_e) m_state = S_RUN;
         default: m_state = S_IDLE;
      endcase
      if (!m_lap) m_disp = pq;
      if (lap_e && ps == S_RUN) m_lap = !m_lap;
      if (m_state == S_CLEAR) m_lap = 1'b0;
      exp_tick = (m_state == S_RUN) && (m_pc == TDIV - 1);
      drive_model(exp_tick, m_state, exp_cnt, exp_ld, exp_roll);
   endtask

   // drivers: one-cycle button pulses (edge reaches the FSM three cycles later)
   task automatic press_ss();
      btn_ss = 1'b1; ss_at = cyc_n + 3;
   endtask

   task automatic press_clr();
      btn_clr = 1'b1; clr_at = cyc_n + 3;
   endtask

`ifdef STOPWATCH_LAP_EN
   task automatic press_lap();
      btn_lap = 1'b1; lap_at = cyc_n + 3;
   endtask
`endif

   task automatic preload(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
      pre_en = 1'b1; pre0 = a; pre1 = b; pre2 = c; pre3 = d;
   endtask

   task automatic test_reset();
      reset = 1'b0; btn_ss = 1'b0; btn_clr = 1'b0;
`ifdef STOPWATCH_LAP_EN
      btn_lap = 1'b0;
`endif
      preload(4'd0, 4'd0, 4'd0, 4'd0);
      repeat (3) @(negedge clk);
      checks++; if (count !== 4'h0) begin errors++; $display("FAIL rst_count got=%h exp=0", count); end
      checks++; if (load !== 4'h0) begin errors++; $display("FAIL rst_load got=%h exp=0", load); end
      checks++; if (load_d !== 4'h0) begin errors++; $display("FAIL rst_load_d got=%h exp=0", load_d); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL rst_tick got=%b exp=0", tick); end
      checks++; if (rollover !== 1'b0) begin errors++; $display("FAIL rst_rollover got=%b exp=0", rollover); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running got=%b exp=0", running); end
      checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL rst_state got=%0d exp=%0d", state_dbg, S_IDLE); end
      checks++;
      if ({disp3, disp2, disp1, disp0} !== 16'h0) begin
         errors++; $display("FAIL rst_disp got=%h exp=0", {disp3, disp2, disp1, disp0});
      end
      reset = 1'b1;
      init_model();
      for (int i = 0; i < 50; i++) begin
         cyc();
         checks++;
         if (count !== 4'h0 || tick !== 1'b0) begin
            errors++; $display("FAIL idle_quiet cyc=%0d count=%h tick=%b exp count=0 tick=0", i, count, tick);
         end
      end
   endtask

   task automatic test_start();
      logic       tk;
      int         k;
      press_ss();
      for (int i = 0; i < 4; i++) begin
         cyc();
         checks++;
         if (running !== (i == 3)) begin
            errors++; $display("FAIL start_latency cyc=%0d running=%b exp=%b", i + 1, running, (i == 3));
         end
      end
      for (int i = 1; i <= 40; i++) begin
         cyc();
         tk = (i % 4 == 3);
         checks++;
         if (tick !== tk) begin errors++; $display("FAIL start_tick i=%0d got=%b exp=%b", i, tick, tk); end
         if (tk) begin
            k = (i - 3) / 4;
            checks++;
            if (q0 !== 4'(k)) begin errors++; $display("FAIL q0_seq i=%0d got=%0d exp=%0d", i, q0, k); end
            checks++;
            if (k < 9) begin
               if (count !== 4'b0001 || load !== 4'b0000) begin
                  errors++; $display("FAIL tick_drive i=%0d count=%b load=%b exp count=0001 load=0000", i, count, load);
               end
            end else begin
               if (count !== 4'b0010 || load !== 4'b0001) begin
                  errors++; $display("FAIL q0_wrap i=%0d count=%b load=%b exp count=0010 load=0001", i, count, load);
               end
            end
         end else begin
            checks++;
            if (count !== 4'h0 || load !== 4'h0) begin
               errors++; $display("FAIL no_tick_drive i=%0d count=%b load=%b exp 0", i, count, load);
            end
         end
         checks++;
         if (disp0 !== m_disp[0]) begin errors++; $display("FAIL disp_lag i=%0d got=%0d exp=%0d", i, disp0, m_disp[0]); end
      end
      checks++;
      if (q1 !== 4'd1 || q0 !== 4'd0) begin
         errors++; $display("FAIL carry_result q1q0=%0d%0d exp=10", q1, q0);
      end
   endtask

   task automatic test_pause_resume();
      cyc(); cyc();
      press_ss();
      for (int i = 1; i <= 4; i++) begin
         cyc();
         checks++;
         if (running !== (i < 4)) begin errors++; $display("FAIL pause_enter i=%0d running=%b exp=%b", i, running, (i < 4)); end
         checks++;
         if (tick !== exp_tick || count !== exp_cnt) begin
            errors++; $display("FAIL pause_tick i=%0d tick=%b count=%b exp tick=%b count=%b", i, tick, count, exp_tick, exp_cnt);
         end
      end
      for (int i = 0; i < 20; i++) begin
         cyc();
         checks++;
         if (tick !== 1'b0 || count !== 4'h0 || running !== 1'b0) begin
            errors++; $display("FAIL pause_quiet i=%0d tick=%b count=%b running=%b exp 0", i, tick, count, running);
         end
      end
      press_ss();
      for (int j = 1; j <= 5; j++) begin
         cyc();
         checks++;
         if (running !== (j >= 4)) begin errors++; $display("FAIL resume_run j=%0d running=%b exp=%b", j, running, (j >= 4)); end
         checks++;
         if (tick !== (j == 5)) begin errors++; $display("FAIL resume_tick j=%0d tick=%b exp=%b", j, tick, (j == 5)); end
      end
      checks++;
      if (count !== 4'b0001) begin errors++; $display("FAIL resume_count got=%b exp=0001", count); end
   endtask

   task automatic test_clr_in_run();
      press_clr();
      for (int i = 0; i < 8; i++) begin
         cyc();
         checks++;
         if (running !== 1'b1 || state_dbg !== S_RUN) begin
            errors++; $display("FAIL clr_ignored i=%0d running=%b state=%0d exp running=1 state=%0d", i, running, state_dbg, S_RUN);
         end
         checks++;
         if (load !== 4'h0) begin errors++; $display("FAIL clr_noload i=%0d load=%b exp=0000", i, load); end
      end
   endtask

   task automatic test_cascade();
      logic found;
      preload(4'd9, 4'd5, 4'd9, 4'd5);
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         checks++;
         if (tick !== exp_tick) begin errors++; $display("FAIL cascade_tick i=%0d got=%b exp=%b", i, tick, exp_tick); end
         if (exp_tick) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL cascade_timeout got=no_tick exp=tick");
      end else if (load !== 4'hF || count !== 4'h0 || rollover !== 1'b1) begin
         errors++; $display("FAIL rollover_drive load=%h count=%h rollover=%b exp load=f count=0 rollover=1", load, count, rollover);
      end
      cyc();
      checks++;
      if ({q3, q2, q1, q0} !== 16'h0000 || rollover !== 1'b0) begin
         errors++; $display("FAIL rollover_after q=%h rollover=%b exp q=0000 rollover=0", {q3, q2, q1, q0}, rollover);
      end
      checks++;
      if (running !== 1'b1) begin errors++; $display("FAIL rollover_keeps_run running=%b exp=1", running); end
      // digits above their terminal value behave as terminal
      preload(4'd12, 4'd7, 4'd0, 4'd0);
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (exp_tick) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL overmax_timeout got=no_tick exp=tick");
      end else if (load !== 4'b0011 || count !== 4'b0100 || rollover !== 1'b0) begin
         errors++; $display("FAIL overmax_drive load=%b count=%b rollover=%b exp load=0011 count=0100 rollover=0", load, count, rollover);
      end
      cyc();
      checks++;
      if ({q3, q2, q1, q0} !== 16'h0100) begin
         errors++; $display("FAIL overmax_after q=%h exp=0100", {q3, q2, q1, q0});
      end
   endtask

   task automatic test_clr_priority();
      press_ss();
      repeat (4) cyc();
      checks++;
      if (state_dbg !== S_PAUSE) begin errors++; $display("FAIL to_pause state=%0d exp=%0d", state_dbg, S_PAUSE); end
      // simultaneous edges in PAUSE: clear wins
      press_ss(); press_clr();
      for (int i = 1; i <= 5; i++) begin
         cyc();
         if (i == 4) begin
            checks++;
            if (state_dbg !== S_CLEAR || load !== 4'hF || count !== 4'h0 || running !== 1'b0) begin
               errors++; $display("FAIL clear_cycle state=%0d load=%h count=%h running=%b exp state=3 load=f count=0 running=0", state_dbg, load, count, running);
            end
         end else if (i == 5) begin
            checks++;
            if (state_dbg !== S_IDLE || load !== 4'h0) begin
               errors++; $display("FAIL clear_to_idle state=%0d load=%h exp state=0 load=0", state_dbg, load);
            end
            checks++;
            if ({q3, q2, q1, q0} !== 16'h0) begin errors++; $display("FAIL clear_loaded q=%h exp=0000", {q3, q2, q1, q0}); end
            checks++;
            if (disp0 !== m_disp[0] || disp1 !== m_disp[1]) begin
               errors++; $display("FAIL disp_follows_q disp1,0=%0d,%0d exp=%0d,%0d", disp1, disp0, m_disp[1], m_disp[0]);
            end
         end else begin
            checks++;
            if (state_dbg !== S_PAUSE) begin errors++; $display("FAIL clear_wait i=%0d state=%0d exp=%0d", i, state_dbg, S_PAUSE); end
         end
      end
      // clear from IDLE
      press_clr();
      for (int i = 1; i <= 5; i++) begin
         cyc();
         checks++;
         if (state_dbg !== m_state) begin errors++; $display("FAIL idle_clear i=%0d state=%0d exp=%0d", i, state_dbg, m_state); end
      end
      // simultaneous edges in RUN: start/stop wins
      press_ss();
      repeat (4) cyc();
      press_ss(); press_clr();
      for (int i = 1; i <= 4; i++) begin
         cyc();
         checks++;
         if (load === 4'hF) begin errors++; $display("FAIL run_both_noclear i=%0d load=%h exp=not f", i, load); end
      end
      checks++;
      if (state_dbg !== S_PAUSE) begin errors++; $display("FAIL run_both_pause state=%0d exp=%0d", state_dbg, S_PAUSE); end
   endtask

   task automatic test_reset_mid();
      logic found;
      preload(4'd5, 4'd3, 4'd0, 4'd0);
      press_ss();
      found = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (exp_tick) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found || tick !== 1'b1) begin errors++; $display("FAIL mid_pre_tick tick=%b exp=1", tick); end
      #1 reset = 1'b0;
      #1;
      checks++;
      if (tick !== 1'b0 || count !== 4'h0 || load !== 4'h0 || running !== 1'b0) begin
         errors++; $display("FAIL mid_reset_out tick=%b count=%h load=%h running=%b exp 0", tick, count, load, running);
      end
      checks++;
      if ({disp3, disp2, disp1, disp0} !== 16'h0 || state_dbg !== S_IDLE) begin
         errors++; $display("FAIL mid_reset_disp disp=%h state=%0d exp disp=0 state=0", {disp3, disp2, disp1, disp0}, state_dbg);
      end
      btn_ss = 1'b0; btn_clr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      init_model();
      cyc();
      checks++;
      if (running !== 1'b0 || disp0 !== m_disp[0]) begin
         errors++; $display("FAIL after_reset running=%b disp0=%0d exp running=0 disp0=%0d", running, disp0, m_disp[0]);
      end
   endtask

`ifdef STOPWATCH_LAP_EN
   task automatic test_lap();
      logic       found;
      logic [3:0] p;
      preload(4'd0, 4'd0, 4'd0, 4'd0);
      press_ss();
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (m_state == S_RUN && q0 == 4'd3 && m_pc == 0) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL lap_setup q0=%0d exp=3", q0); end
      press_lap();
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         checks++;
         if (disp0 !== 4'd3) begin errors++; $display("FAIL lap_hold i=%0d disp0=%0d exp=3 q0=%0d", i, disp0, q0); end
         if (q0 == 4'd7) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL lap_q0_reach q0=%0d exp=7", q0); end
      press_lap();
      for (int i = 0; i < 5; i++) begin
         cyc();
         checks++;
         if (disp0 !== m_disp[0]) begin errors++; $display("FAIL lap_release i=%0d disp0=%0d exp=%0d", i, disp0, m_disp[0]); end
      end
      for (int i = 0; i < 6; i++) begin
         p = q0;
         cyc();
         checks++;
         if (disp0 !== p) begin errors++; $display("FAIL lap_track i=%0d disp0=%0d exp=%0d", i, disp0, p); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_start();
      test_pause_resume();
      test_clr_in_run();
      test_cascade();
      test_clr_priority();
      test_reset_mid();
`ifdef STOPWATCH_LAP_EN
      test_lap();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
